dc_mcl_conf_commit: RTL and testbench

//  Downstream consumer of the config manager's conf_* bus: takes one config per conf_valid/conf_ready

---
 rtl/dc_mcl_pkg.sv | 37 +++
 rtl/dc_mcl_serial_divider.sv | 76 +++++++
 rtl/dc_mcl_conf_commit.sv | 223 ++++++++++++++++++++++
 tb/tb_dc_mcl_conf_commit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/dc_mcl_pkg.sv
// Shared types and widths for the config commit block: FSM state, config payload, step width.
package dc_mcl_pkg;

   localparam int unsigned SCR_SIZE_WIDTH     = 12;
   localparam int unsigned AXI_ARADDR_WIDTH   = 32;
   localparam int unsigned RGB_WIDTH          = 24;
   localparam int unsigned SCALE_METHOD_WIDTH = 2;
   localparam int unsigned STEP_FRAC_WIDTH    = 16;

   function automatic int unsigned calc_step_w(input int unsigned scr_w, input int unsigned frac_w);
      return scr_w + frac_w;
   endfunction

   localparam int unsigned STEP_W = calc_step_w(SCR_SIZE_WIDTH, STEP_FRAC_WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CALC_X  = 2'd1,
      ST_CALC_Y  = 2'd2,
      ST_PENDING = 2'd3
   } commit_state_e;

   typedef struct packed {
      logic [SCR_SIZE_WIDTH-1:0]     screen_width;
      logic [SCR_SIZE_WIDTH-1:0]     screen_height;
      logic [SCR_SIZE_WIDTH-1:0]     tex_width;
      logic [SCR_SIZE_WIDTH-1:0]     tex_height;
      logic [SCR_SIZE_WIDTH-1:0]     image_width;
      logic [SCR_SIZE_WIDTH-1:0]     image_height;
      logic [SCR_SIZE_WIDTH-1:0]     image_offset_x;
      logic [SCR_SIZE_WIDTH-1:0]     image_offset_y;
      logic [SCALE_METHOD_WIDTH-1:0] scale_method;
      logic [RGB_WIDTH-1:0]          border_color;
      logic [AXI_ARADDR_WIDTH-1:0]   tex_address;
   } conf_t;

endpackage

// File: rtl/dc_mcl_serial_divider.sv
// Restoring unsigned divider, one quotient bit per enabled cycle, MSB first.
// done_c/quot_c flag the final iteration so the caller can chain a new start on the same edge.
module dc_mcl_serial_divider #(
   parameter int unsigned DIVIDEND_W = 28,
   parameter int unsigned DIVISOR_W  = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  busy,
   output logic                  done_c,
   output logic [DIVIDEND_W-1:0] quot_c
);

   localparam int unsigned CNT_W = $clog2(DIVIDEND_W + 1);
   localparam int unsigned REM_W = DIVISOR_W + 1;

   logic [DIVISOR_W-1:0]  rem_q, rem_d, rem_nx;
   logic [DIVIDEND_W-1:0] acc_q, acc_d, acc_nx;
   logic [DIVISOR_W-1:0]  divisor_q, divisor_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  busy_q, busy_d;
   logic [REM_W-1:0]      rem_sh;
   logic                  ge;

   // acc holds the remaining dividend bits in its top and collects quotient bits at the bottom
   always_comb begin
      rem_sh = {rem_q, acc_q[DIVIDEND_W-1]};
      ge     = rem_sh >= {1'b0, divisor_q};
      rem_nx = ge ? DIVISOR_W'(rem_sh - {1'b0, divisor_q}) : DIVISOR_W'(rem_sh);
      acc_nx = {acc_q[DIVIDEND_W-2:0], ge};
      done_c = busy_q && (cnt_q == CNT_W'(1));
      quot_c = acc_nx;

      rem_d     = rem_q;
      acc_d     = acc_q;
      divisor_d = divisor_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      if (busy_q) begin
         rem_d  = rem_nx;
         acc_d  = acc_nx;
         cnt_d  = cnt_q - CNT_W'(1);
         busy_d = !done_c;
      end
      if (start) begin
         rem_d     = '0;
         acc_d     = dividend;
         divisor_d = divisor;
         cnt_d     = CNT_W'(DIVIDEND_W);
         busy_d    = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q     <= '0;
         acc_q     <= '0;
         divisor_q <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
      end else if (en) begin
         rem_q     <= rem_d;
         acc_q     <= acc_d;
         divisor_q <= divisor_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
      end
   end

   assign busy = busy_q;

endmodule

// File: rtl/dc_mcl_conf_commit.sv
// Captures one config into a shadow set, derives texture steps and visible window,
// and commits everything to act_* on the first frame_start after the steps are ready.
module dc_mcl_conf_commit
   import dc_mcl_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic [SCR_SIZE_WIDTH-1:0]     conf_screen_width,
   input  logic [SCR_SIZE_WIDTH-1:0]     conf_screen_height,
   input  logic [SCR_SIZE_WIDTH-1:0]     conf_tex_width,
   input  logic [SCR_SIZE_WIDTH-1:0]     conf_tex_height,
   input  logic [SCR_SIZE_WIDTH-1:0]     conf_image_width,
   input  logic [SCR_SIZE_WIDTH-1:0]     conf_image_height,
   input  logic [SCR_SIZE_WIDTH-1:0]     conf_image_offset_x,
   input  logic [SCR_SIZE_WIDTH-1:0]     conf_image_offset_y,
   input  logic [SCALE_METHOD_WIDTH-1:0] conf_scale_method,
   input  logic [RGB_WIDTH-1:0]          conf_border_color,
   input  logic [AXI_ARADDR_WIDTH-1:0]   conf_tex_address,
   input  logic                          conf_valid,
   output logic                          conf_ready,
   input  logic                          frame_start,
   output logic [SCR_SIZE_WIDTH-1:0]     act_screen_width,
   output logic [SCR_SIZE_WIDTH-1:0]     act_screen_height,
   output logic [SCR_SIZE_WIDTH-1:0]     act_tex_width,
   output logic [SCR_SIZE_WIDTH-1:0]     act_tex_height,
   output logic [SCR_SIZE_WIDTH-1:0]     act_image_width,
   output logic [SCR_SIZE_WIDTH-1:0]     act_image_height,
   output logic [SCR_SIZE_WIDTH-1:0]     act_image_offset_x,
   output logic [SCR_SIZE_WIDTH-1:0]     act_image_offset_y,
   output logic [SCALE_METHOD_WIDTH-1:0] act_scale_method,
   output logic [RGB_WIDTH-1:0]          act_border_color,
   output logic [AXI_ARADDR_WIDTH-1:0]   act_tex_address,
   output logic [STEP_W-1:0]             act_step_x,
   output logic [STEP_W-1:0]             act_step_y,
   output logic [SCR_SIZE_WIDTH-1:0]     act_vis_x_end,
   output logic [SCR_SIZE_WIDTH-1:0]     act_vis_y_end,
   output logic                          act_visible,
   output logic                          act_loaded,
   output logic                          act_update,
   output logic                          conf_error
);

   localparam int unsigned SUM_W = SCR_SIZE_WIDTH + 1;

   commit_state_e             state_q, state_d;
   conf_t                     conf_in_c;
   conf_t                     shadow_q, shadow_d;
   conf_t                     act_q, act_d;
   logic [STEP_W-1:0]         step_x_q, step_x_d, step_y_q, step_y_d;
   logic [STEP_W-1:0]         act_step_x_q, act_step_x_d, act_step_y_q, act_step_y_d;
   logic [SCR_SIZE_WIDTH-1:0] act_vis_x_end_q, act_vis_x_end_d, act_vis_y_end_q, act_vis_y_end_d;
   logic                      act_visible_q, act_visible_d;
   logic                      act_loaded_q, act_loaded_d;
   logic                      act_update_q, act_update_d;
   logic                      conf_ready_q, conf_ready_d;
   logic                      conf_error_q, conf_error_d;

   logic                      div_start_c, div_busy, div_done_c;
   logic [STEP_W-1:0]         div_dividend_c, div_quot_c;
   logic [SCR_SIZE_WIDTH-1:0] div_divisor_c;

   logic [SUM_W-1:0]          sum_x_c, sum_y_c;
   logic [SCR_SIZE_WIDTH-1:0] vis_x_end_c, vis_y_end_c;
   logic                      visible_c;

   assign conf_in_c = '{screen_width:   conf_screen_width,   screen_height:  conf_screen_height,
                        tex_width:      conf_tex_width,      tex_height:     conf_tex_height,
                        image_width:    conf_image_width,    image_height:   conf_image_height,
                        image_offset_x: conf_image_offset_x, image_offset_y: conf_image_offset_y,
                        scale_method:   conf_scale_method,   border_color:   conf_border_color,
                        tex_address:    conf_tex_address};

   // Visible window from the shadow set; the extra sum bit keeps offset+dim from wrapping
   always_comb begin
      sum_x_c     = SUM_W'(shadow_q.image_offset_x) + SUM_W'(shadow_q.image_width);
      sum_y_c     = SUM_W'(shadow_q.image_offset_y) + SUM_W'(shadow_q.image_height);
      vis_x_end_c = (sum_x_c > SUM_W'(shadow_q.screen_width))  ? shadow_q.screen_width
                                                               : SCR_SIZE_WIDTH'(sum_x_c);
      vis_y_end_c = (sum_y_c > SUM_W'(shadow_q.screen_height)) ? shadow_q.screen_height
                                                               : SCR_SIZE_WIDTH'(sum_y_c);
      visible_c   = (shadow_q.image_offset_x < shadow_q.screen_width) &&
                    (shadow_q.image_offset_y < shadow_q.screen_height) &&
                    (shadow_q.image_width != '0) && (shadow_q.image_height != '0);
   end

   always_comb begin
      state_d         = state_q;
      shadow_d        = shadow_q;
      step_x_d        = step_x_q;
      step_y_d        = step_y_q;
      act_d           = act_q;
      act_step_x_d    = act_step_x_q;
      act_step_y_d    = act_step_y_q;
      act_vis_x_end_d = act_vis_x_end_q;
      act_vis_y_end_d = act_vis_y_end_q;
      act_visible_d   = act_visible_q;
      act_loaded_d    = act_loaded_q;
      act_update_d    = 1'b0;
      conf_ready_d    = conf_ready_q;
      conf_error_d    = conf_error_q;
      div_start_c     = 1'b0;
      div_dividend_c  = '0;
      div_divisor_c   = '0;

      case (state_q)
         ST_IDLE: begin
            conf_ready_d = !div_busy;
            if (conf_valid && conf_ready_q) begin
               shadow_d       = conf_in_c;
               conf_ready_d   = 1'b0;
               div_start_c    = 1'b1;
               div_dividend_c = {conf_tex_width, {STEP_FRAC_WIDTH{1'b0}}};
               div_divisor_c  = conf_image_width;
               if ((conf_image_width == '0) || (conf_image_height == '0)) conf_error_d = 1'b1;
               state_d        = ST_CALC_X;
            end
         end
         ST_CALC_X: begin
            // Chain the height division on the edge the width result lands
            if (div_done_c) begin
               step_x_d       = div_quot_c;
               div_start_c    = 1'b1;
               div_dividend_c = {shadow_q.tex_height, {STEP_FRAC_WIDTH{1'b0}}};
               div_divisor_c  = shadow_q.image_height;
               state_d        = ST_CALC_Y;
            end
         end
         ST_CALC_Y: begin
            if (div_done_c) begin
               step_y_d = div_quot_c;
               state_d  = ST_PENDING;
            end
         end
         ST_PENDING: begin
            if (frame_start) begin
               act_d           = shadow_q;
               act_step_x_d    = step_x_q;
               act_step_y_d    = step_y_q;
               act_vis_x_end_d = vis_x_end_c;
               act_vis_y_end_d = vis_y_end_c;
               act_visible_d   = visible_c;
               act_loaded_d    = 1'b1;
               act_update_d    = 1'b1;
               conf_ready_d    = 1'b1;
               state_d         = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         shadow_q        <= '0;
         step_x_q        <= '0;
         step_y_q        <= '0;
         act_q           <= '0;
         act_step_x_q    <= '0;
         act_step_y_q    <= '0;
         act_vis_x_end_q <= '0;
         act_vis_y_end_q <= '0;
         act_visible_q   <= 1'b0;
         act_loaded_q    <= 1'b0;
         act_update_q    <= 1'b0;
         conf_ready_q    <= 1'b0;
         conf_error_q    <= 1'b0;
      end else if (en) begin
         state_q         <= state_d;
         shadow_q        <= shadow_d;
         step_x_q        <= step_x_d;
         step_y_q        <= step_y_d;
         act_q           <= act_d;
         act_step_x_q    <= act_step_x_d;
         act_step_y_q    <= act_step_y_d;
         act_vis_x_end_q <= act_vis_x_end_d;
         act_vis_y_end_q <= act_vis_y_end_d;
         act_visible_q   <= act_visible_d;
         act_loaded_q    <= act_loaded_d;
         act_update_q    <= act_update_d;
         conf_ready_q    <= conf_ready_d;
         conf_error_q    <= conf_error_d;
      end
   end

   dc_mcl_serial_divider #(
      .DIVIDEND_W (STEP_W),
      .DIVISOR_W  (SCR_SIZE_WIDTH)
   ) u_div (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .start    (div_start_c),
      .dividend (div_dividend_c),
      .divisor  (div_divisor_c),
      .busy     (div_busy),
      .done_c   (div_done_c),
      .quot_c   (div_quot_c)
   );

   assign act_screen_width   = act_q.screen_width;
   assign act_screen_height  = act_q.screen_height;
   assign act_tex_width      = act_q.tex_width;
   assign act_tex_height     = act_q.tex_height;
   assign act_image_width    = act_q.image_width;
   assign act_image_height   = act_q.image_height;
   assign act_image_offset_x = act_q.image_offset_x;
   assign act_image_offset_y = act_q.image_offset_y;
   assign act_scale_method   = act_q.scale_method;
   assign act_border_color   = act_q.border_color;
   assign act_tex_address    = act_q.tex_address;
   assign act_step_x         = act_step_x_q;
   assign act_step_y         = act_step_y_q;
   assign act_vis_x_end      = act_vis_x_end_q;
   assign act_vis_y_end      = act_vis_y_end_q;
   assign act_visible        = act_visible_q;
   assign act_loaded         = act_loaded_q;
   assign act_update         = act_update_q;
   assign conf_ready         = conf_ready_q;
   assign conf_error         = conf_error_q;

endmodule

// File: tb/tb_dc_mcl_conf_commit.sv
// Scoreboard bench for dc_mcl_conf_commit: expected commits queued at capture, checked on act_update.
module tb_dc_mcl_conf_commit;
   import dc_mcl_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b1;
   always #5 clk = ~clk;

   conf_t       cin = '0;
   logic        conf_valid  = 1'b0;
   logic        frame_start = 1'b0;
   logic        conf_ready, act_visible, act_loaded, act_update, conf_error;
   logic [11:0] act_screen_width, act_screen_height, act_tex_width, act_tex_height;
   logic [11:0] act_image_width, act_image_height, act_image_offset_x, act_image_offset_y;
   logic [1:0]  act_scale_method;
   logic [23:0] act_border_color;
   logic [31:0] act_tex_address;
   logic [27:0] act_step_x, act_step_y;
   logic [11:0] act_vis_x_end, act_vis_y_end;

   dc_mcl_conf_commit dut (
      .clk(clk), .rst(rst), .en(en),
      .conf_screen_width(cin.screen_width), .conf_screen_height(cin.screen_height),
      .conf_tex_width(cin.tex_width), .conf_tex_height(cin.tex_height),
      .conf_image_width(cin.image_width), .conf_image_height(cin.image_height),
      .conf_image_offset_x(cin.image_offset_x), .conf_image_offset_y(cin.image_offset_y),
      .conf_scale_method(cin.scale_method), .conf_border_color(cin.border_color),
      .conf_tex_address(cin.tex_address), .conf_valid(conf_valid), .conf_ready(conf_ready),
      .frame_start(frame_start),
      .act_screen_width(act_screen_width), .act_screen_height(act_screen_height),
      .act_tex_width(act_tex_width), .act_tex_height(act_tex_height),
      .act_image_width(act_image_width), .act_image_height(act_image_height),
      .act_image_offset_x(act_image_offset_x), .act_image_offset_y(act_image_offset_y),
      .act_scale_method(act_scale_method), .act_border_color(act_border_color),
      .act_tex_address(act_tex_address), .act_step_x(act_step_x), .act_step_y(act_step_y),
      .act_vis_x_end(act_vis_x_end), .act_vis_y_end(act_vis_y_end), .act_visible(act_visible),
      .act_loaded(act_loaded), .act_update(act_update), .conf_error(conf_error)
   );

   typedef struct {
      conf_t       c;
      logic [27:0] sx, sy;
      logic [11:0] vx, vy;
      logic        vis;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [27:0] last_sx = '0;
   logic        last_loaded = 1'b0;
   logic        err_exp = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [27:0] exp_step(input logic [11:0] tex, input logic [11:0] img);
      logic [27:0] num;
      num = {tex, 16'h0000};
      if (img == 12'd0) return 28'hFFFFFFF;
      return num / {16'h0000, img};
   endfunction

   function automatic logic [11:0] exp_end(input logic [11:0] off, input logic [11:0] dim,
                                           input logic [11:0] scr);
      int s;
      s = int'(off) + int'(dim);
      return (s > int'(scr)) ? scr : 12'(s);
   endfunction

   function automatic conf_t mk(input int sw, input int sh, input int tw, input int th,
                                input int iw, input int ih, input int ox, input int oy);
      conf_t c;
      c.screen_width   = 12'(sw);  c.screen_height  = 12'(sh);
      c.tex_width      = 12'(tw);  c.tex_height     = 12'(th);
      c.image_width    = 12'(iw);  c.image_height   = 12'(ih);
      c.image_offset_x = 12'(ox);  c.image_offset_y = 12'(oy);
      c.scale_method   = 2'($urandom_range(3));
      c.border_color   = 24'($urandom);
      c.tex_address    = $urandom;
      return c;
   endfunction

   task automatic compare_pop();
      exp_t e;
      chk("sb_size", 64'(sb.size()), 64'd1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      chk("step_x", act_step_x, e.sx);
      chk("step_y", act_step_y, e.sy);
      chk("vis_x_end", act_vis_x_end, e.vx);
      chk("vis_y_end", act_vis_y_end, e.vy);
      chk("visible", act_visible, e.vis);
      chk("loaded", act_loaded, 1);
      chk("tex_address", act_tex_address, e.c.tex_address);
      chk("border_color", act_border_color, e.c.border_color);
      chk("scale_method", act_scale_method, e.c.scale_method);
      chk("screen_width", act_screen_width, e.c.screen_width);
      chk("offset_y", act_image_offset_y, e.c.image_offset_y);
      chk("ready_after_commit", conf_ready, 1);
      chk("conf_error", conf_error, err_exp);
      last_sx     = e.sx;
      last_loaded = 1'b1;
   endtask

   // k counts edges after the capture edge; frame_start is sampled on edges fs_a/fs_b
   task automatic run_cfg(input conf_t c, input int fs_a, input int fs_b,
                          input int stall_at, input int stall_len, input int stray_at);
      exp_t e;
      int   n = 0;
      int   pend, commit, got;
      while (!conf_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("ready_before_cfg", conf_ready, 1);
      cin        = c;
      conf_valid = 1'b1;
      e.c   = c;
      e.sx  = exp_step(c.tex_width, c.image_width);
      e.sy  = exp_step(c.tex_height, c.image_height);
      e.vx  = exp_end(c.image_offset_x, c.image_width, c.screen_width);
      e.vy  = exp_end(c.image_offset_y, c.image_height, c.screen_height);
      e.vis = (c.image_offset_x < c.screen_width) && (c.image_offset_y < c.screen_height) &&
              (c.image_width != 0) && (c.image_height != 0);
      sb.push_back(e);
      if (c.image_width == 0 || c.image_height == 0) err_exp = 1'b1;
      @(negedge clk);
      conf_valid = 1'b0;
      chk("ready_low_after_capture", conf_ready, 0);
      pend   = 2 * int'(STEP_W) + 1 + stall_len;
      commit = (fs_a >= pend) ? fs_a : fs_b;
      got    = 0;
      for (int k = 1; k <= commit + 3; k++) begin
         frame_start = (k == fs_a) || (k == fs_b);
         en          = !(stall_len > 0 && k >= stall_at && k < stall_at + stall_len);
         conf_valid  = (k == stray_at) || (k == stray_at + 1);
         cin         = conf_valid ? mk(640, 480, 16, 16, 7, 9, 1, 1) : c;
         @(negedge clk);
         if (k == pend - 1) begin
            chk("act_held_step_x", act_step_x, last_sx);
            chk("act_held_loaded", act_loaded, last_loaded);
         end
         if (got != 0 && k == got + 1) chk("update_pulse_width", act_update, 0);
         if (act_update && got == 0) begin
            got = k;
            compare_pop();
         end
      end
      frame_start = 1'b0;
      conf_valid  = 1'b0;
      en          = 1'b1;
      cin         = c;
      chk("commit_cycle", 64'(got), 64'(commit));
      if (got == 0 && sb.size() != 0) void'(sb.pop_front());
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_step_x", act_step_x, 0);
      chk("rst_vis_x_end", act_vis_x_end, 0);
      chk("rst_tex_address", act_tex_address, 0);
      chk("rst_visible", act_visible, 0);
      chk("rst_loaded", act_loaded, 0);
      chk("rst_update", act_update, 0);
      chk("rst_conf_error", conf_error, 0);
      chk("rst_ready", conf_ready, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", conf_ready, 1);

      // baseline; frame_start on the edge PENDING is entered must be ignored, stray valid in CALC
      run_cfg(mk(1280, 720, 320, 240, 640, 480, 0, 0), 56, 66, 0, 0, 30);
      run_cfg(mk(1280, 720, 320, 240, 160, 120, 0, 0), 57, 0, 0, 0, 0);
      run_cfg(mk(1280, 720, 320, 240, 1280, 720, 0, 0), 20, 60, 0, 0, 0);
      run_cfg(mk(1280, 720, 320, 240, 640, 480, 960, 100), 58, 0, 0, 0, 0);
      run_cfg(mk(1280, 720, 320, 240, 640, 480, 1920, 0), 57, 0, 0, 0, 0);
      // zero width plus a 20-cycle enable stall while the width divides
      run_cfg(mk(1280, 720, 320, 240, 0, 480, 0, 0), 76, 77, 10, 20, 0);
      run_cfg(mk(1280, 720, 320, 240, 640, 480, 0, 0), 57, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++)
         run_cfg(mk(1280, 720, int'($urandom_range(4095, 1)), int'($urandom_range(4095, 1)),
                    int'($urandom_range(4095, 1)), int'($urandom_range(4095, 1)),
                    int'($urandom_range(2047)), int'($urandom_range(1023))), 60, 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
